mpu_mul_sequencer: RTL

Sequential controller for the MPU matrix-multiply path. It latches two 5x5 8-bit operand matrices and an active size n, then computes the n x n product with a single 8x8 multiply-accumulate unit, iterating over rows, columns and the inner index. Elements outside the active n x n window are zeroed. It sits between the MPU instruction decoder, which issues `start`, and the result writeback, which consumes `result` on `done`. It trades the fully parallel 125-multiplier product for one multiplier and n³ cycles.

---
 rtl/mpu_mul_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/mpu_mul_sequencer.sv
// Sequential n x n matrix multiply over latched 5x5 operands using a single
// 8x8 MAC; one multiply per cycle, results held until the next accept.
module mpu_mul_sequencer #(
    parameter int DIM = 5,
    parameter int W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             size,
    input  logic [DIM*DIM*W-1:0]   matrix_a,
    input  logic [DIM*DIM*W-1:0]   matrix_b,
    output logic                   busy,
    output logic                   done,
    output logic [DIM*DIM*W-1:0]   result
);

    localparam int IW = $clog2(DIM + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_in  [DIM][DIM];
    logic [W-1:0]    b_in  [DIM][DIM];
    logic [W-1:0]    a_q   [DIM][DIM];
    logic [W-1:0]    b_q   [DIM][DIM];
    logic [W-1:0]    res_q [DIM][DIM];
    logic [IW-1:0]   n_q;
    logic [IW-1:0]   n_in;
    logic [IW-1:0]   last;
    logic [IW-1:0]   i;
    logic [IW-1:0]   j;
    logic [IW-1:0]   k;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  sum;

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            assign a_in[gi][gj] = matrix_a[(gi*DIM+gj)*W +: W];
            assign b_in[gi][gj] = matrix_b[(gi*DIM+gj)*W +: W];
            assign result[(gi*DIM+gj)*W +: W] = res_q[gi][gj];
        end
    end

    always_comb begin
        n_in = (size > 8'(DIM)) ? IW'(DIM) : size[IW-1:0];
        last = n_q - IW'(1);
        prod = {{W{1'b0}}, a_q[i][k]} * {{W{1'b0}}, b_q[k][j]};
        sum  = acc + prod;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            n_q   <= '0;
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            res_q <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        n_q   <= n_in;
                        res_q <= '{default: '0};
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        if (n_in == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (k != last) begin
                        acc <= sum;
                        k   <= k + IW'(1);
                    end else begin
                        // final term of the dot product goes straight to the result
                        res_q[i][j] <= sum[W-1:0];
                        acc         <= '0;
                        k           <= '0;
                        if (j == last) begin
                            j <= '0;
                            i <= i + IW'(1);
                            if (i == last) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            j <= j + IW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
